// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
//   mul_state_t : control state (IDLE, RUN, DONE)
//   MUL_CYCLES  : fixed number of RUN iterations, one per multiplier bit
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_CYCLES = 32;

endpackage : mul_pkg

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder built from bit-level gates.
//   a, b : addends
//   cin  : carry in
//   sum  : 32-bit sum
//   cout : carry out of bit 31
module adder_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    // Carry chain evaluated LSB to MSB inside one procedure.
    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        cout = c;
    end

endmodule : adder_32bit

// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32->64 shift-and-add multiplier, one multiplier bit per cycle.
//   clk     : clock, all state updates on rising edge
//   reset   : synchronous active-high reset
//   start   : operation request, honoured only in IDLE or DONE
//   a, b    : multiplicand / multiplier, captured on accepted start
//   busy    : high while iterating
//   done    : one-cycle pulse, product valid
//   product : {hi,lo} partial-product registers
module seq_multiplier_32bit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    // Multiplicand is added only when the current multiplier bit is set.
    assign add_b = lo_q[0] ? m_q : '0;

    adder_32bit u_adder (
        .a    (hi_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    m_d     = a;
                    hi_d    = '0;
                    lo_d    = b;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Shift {cout,sum,lo} right by one; carry lands in hi MSB.
                hi_d = {add_cout, add_sum[WIDTH-1:1]};
                lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = {hi_q, lo_q};

endmodule : seq_multiplier_32bit

// File: tb/tb_seq_multiplier_32bit.sv
// Self-checking bench for seq_multiplier_32bit: scoreboard of expected
// products popped on each done pulse, plus per-cycle busy/done timing.
module tb_seq_multiplier_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];

    seq_multiplier_32bit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard consumer and busy/done exclusivity.
    always @(negedge clk) begin
        check("busy_done_excl", 64'(busy & done), 64'd0);
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    // One operation from IDLE; optional start pulse with new operands at RUN cycle 'poke'.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [63:0] e;
        e = 64'(x) * 64'(y);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("busy", 64'(busy), 64'd1);
            check("done_early", 64'(done), 64'd0);
            if (i == poke) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_at_33", 64'(done), 64'd1);
        check("busy_off", 64'(busy), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("hold_idle", product, e);
    endtask

    // Two operations with start held through DONE.
    task automatic do_b2b(input logic [31:0] x1, input logic [31:0] y1,
                          input logic [31:0] x2, input logic [31:0] y2);
        @(posedge clk);
        #1;
        a = x1;
        b = y1;
        start = 1'b1;
        exp_q.push_back(64'(x1) * 64'(y1));
        @(posedge clk);
        #1;
        a = x2;
        b = y2;
        exp_q.push_back(64'(x2) * 64'(y2));
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("b2b_busy1", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("b2b_done1", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("b2b_busy2", 64'(busy), 64'd1);
        end
        @(negedge clk);
        check("b2b_done2", 64'(done), 64'd1);
        @(negedge clk);
        check("b2b_idle", 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        reset = 1'b0;

        do_op(32'd3, 32'd5, 0);
        check("p_3x5", product, 64'h0000_0000_0000_000F);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("p_max", product, 64'hFFFF_FFFE_0000_0001);
        do_op(32'd0, 32'h1234_5678, 0);
        check("p_zero", product, 64'd0);
        do_op(32'h8000_0000, 32'd2, 0);
        check("p_msb", product, 64'h0000_0001_0000_0000);

        // Start ignored mid-RUN.
        do_op(32'hDEAD_BEEF, 32'h0000_1234, 10);

        // Reset at RUN cycle 10 abandons the operation.
        @(posedge clk);
        #1;
        a = 32'h1111_2222;
        b = 32'h3333_4444;
        start = 1'b1;
        exp_q.push_back(64'(a) * 64'(b));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_product", product, 64'd0);
        exp_q.delete();
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);
        do_op(32'd7, 32'd9, 0);

        do_b2b(32'h0001_0001, 32'hFFFF_0000, 32'h1234_5678, 32'h9ABC_DEF0);

        for (int n = 0; n < 1000; n++) begin
            do_op($urandom, $urandom, 0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seq_multiplier_32bit
